// File: rtl/cpu_pkg.sv
// Shared CPU types: register address and data word widths, the zero register,
// and the write-back request record.
package cpu_pkg;
    localparam int REG_AW = 5;
    localparam int XLEN   = 32;

    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]   word_t;

    localparam reg_addr_t REG_ZERO = '0;

    typedef struct packed {
        reg_addr_t rd;
        word_t     data;
    } wb_req_t;
endpackage

// File: rtl/regfile_wb_queue_if.sv
// Producer / regfile bus of the write-back queue. The forwarding lookup
// signals exist only when WBQ_BYPASS_EN is defined.
interface regfile_wb_queue_if #(
    parameter int DW = cpu_pkg::XLEN,
    parameter int AW = cpu_pkg::REG_AW
);
    logic          wb_valid;
    logic          wb_ready;
    logic [AW-1:0] wb_rd;
    logic [DW-1:0] wb_data;
    logic          rf_hold;
    logic [AW-1:0] rd;
    logic [DW-1:0] input_data;
    logic          write;
`ifdef WBQ_BYPASS_EN
    logic [AW-1:0] rs, rt;
    logic          rs_hit, rt_hit;
    logic [DW-1:0] rs_fwd, rt_fwd;
`endif

    modport master (
        output wb_valid, wb_rd, wb_data, rf_hold,
        input  wb_ready, rd, input_data, write
`ifdef WBQ_BYPASS_EN
        , output rs, rt
        , input  rs_hit, rt_hit, rs_fwd, rt_fwd
`endif
    );

    modport slave (
        input  wb_valid, wb_rd, wb_data, rf_hold,
        output wb_ready, rd, input_data, write
`ifdef WBQ_BYPASS_EN
        , input  rs, rt
        , output rs_hit, rt_hit, rs_fwd, rt_fwd
`endif
    );
endinterface

// File: rtl/wbq_fifo.sv
// In-order storage of the write-back queue: pointers, occupancy count and
// per-entry valid bits. Entry view is exported when WBQ_BYPASS_EN is defined.
module wbq_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 32,
    parameter int AW    = 5,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [AW-1:0] push_rd,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic          full,
    output logic          empty,
    output logic [AW-1:0] head_rd,
    output logic [DW-1:0] head_data
`ifdef WBQ_BYPASS_EN
    ,
    output logic [DEPTH-1:0]         ent_vld,
    output logic [DEPTH-1:0][AW-1:0] ent_rd,
    output logic [DEPTH-1:0][DW-1:0] ent_data,
    output logic [PW-1:0]            head_ptr
`endif
);
    logic [DEPTH-1:0][AW-1:0] mem_rd;
    logic [DEPTH-1:0][DW-1:0] mem_data;
    logic [DEPTH-1:0]         vld;
    logic [PW-1:0]            wr_ptr, rd_ptr;
    logic [CW-1:0]            count;

    // Push and pop never target the same slot: push needs !full, pop needs !empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            vld    <= '0;
        end else begin
            if (push) begin
                wr_ptr      <= wr_ptr + 1'b1;
                vld[wr_ptr] <= 1'b1;
            end
            if (pop) begin
                rd_ptr      <= rd_ptr + 1'b1;
                vld[rd_ptr] <= 1'b0;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_rd[wr_ptr]   <= push_rd;
            mem_data[wr_ptr] <= push_data;
        end
    end

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign head_rd   = vld[rd_ptr] ? mem_rd[rd_ptr]   : '0;
    assign head_data = vld[rd_ptr] ? mem_data[rd_ptr] : '0;

`ifdef WBQ_BYPASS_EN
    assign ent_vld  = vld;
    assign ent_rd   = mem_rd;
    assign ent_data = mem_data;
    assign head_ptr = rd_ptr;
`endif
endmodule

// File: rtl/regfile_wb_queue.sv
// Write-back queue owning the regfile write port: r0 discard, hold gating and,
// with WBQ_BYPASS_EN defined, youngest-entry forwarding for rs/rt.
module regfile_wb_queue
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = XLEN,
    parameter int AW    = REG_AW
) (
    input logic clk,
    input logic rst,
    regfile_wb_queue_if.slave bus
);
    localparam int PW = $clog2(DEPTH);

    logic          push, pop, full, empty;
    logic [AW-1:0] head_rd;
    logic [DW-1:0] head_data;

    // r0 writes complete the handshake but never occupy a slot.
    assign push = bus.wb_valid && !full && (bus.wb_rd != AW'(REG_ZERO));
    assign pop  = !empty && !bus.rf_hold;

    assign bus.wb_ready   = !full;
    assign bus.write      = pop;
    assign bus.rd         = head_rd;
    assign bus.input_data = head_data;

`ifdef WBQ_BYPASS_EN
    logic [DEPTH-1:0]         ent_vld;
    logic [DEPTH-1:0][AW-1:0] ent_rd;
    logic [DEPTH-1:0][DW-1:0] ent_data;
    logic [PW-1:0]            head_ptr;
`endif

    wbq_fifo #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_rd   (bus.wb_rd),
        .push_data (bus.wb_data),
        .pop       (pop),
        .full      (full),
        .empty     (empty),
        .head_rd   (head_rd),
        .head_data (head_data)
`ifdef WBQ_BYPASS_EN
        ,
        .ent_vld   (ent_vld),
        .ent_rd    (ent_rd),
        .ent_data  (ent_data),
        .head_ptr  (head_ptr)
`endif
    );

`ifdef WBQ_BYPASS_EN
    // Walk oldest to youngest so the last match, the youngest, wins.
    function automatic logic [DW:0] lookup(
        input logic [AW-1:0]              a,
        input logic [DEPTH-1:0]           v,
        input logic [DEPTH-1:0][AW-1:0]   r,
        input logic [DEPTH-1:0][DW-1:0]   d,
        input logic [PW-1:0]              h
    );
        logic [DW:0]   res;
        logic [PW-1:0] idx;
        res = '0;
        idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = h + PW'(k);
            if (v[idx] && (r[idx] == a) && (a != AW'(REG_ZERO)))
                res = {1'b1, d[idx]};
        end
        return res;
    endfunction

    assign {bus.rs_hit, bus.rs_fwd} = lookup(bus.rs, ent_vld, ent_rd, ent_data, head_ptr);
    assign {bus.rt_hit, bus.rt_fwd} = lookup(bus.rt, ent_vld, ent_rd, ent_data, head_ptr);
`endif
endmodule

// File: tb/tb_regfile_wb_queue.sv
// Bench for regfile_wb_queue: directed scenarios plus a randomized run checked
// against a queue-based model. Forwarding checks compile in with WBQ_BYPASS_EN.
module tb_regfile_wb_queue;
    localparam int DEPTH = 4;
    localparam int DW    = 32;
    localparam int AW    = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_wb_queue_if #(.DW(DW), .AW(AW)) bus ();

    regfile_wb_queue #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    // Model: pending writes oldest-first, each {rd, data}.
    logic [AW+DW-1:0] mq[$];
    logic             e_write, e_ready;
    logic [AW-1:0]    e_rd;
    logic [DW-1:0]    e_data;

    task automatic drive(input logic v, input logic [AW-1:0] r, input logic [DW-1:0] d, input logic h);
        bus.wb_valid = v;
        bus.wb_rd    = r;
        bus.wb_data  = d;
        bus.rf_hold  = h;
    endtask

    task automatic predict();
        e_ready = (mq.size() < DEPTH);
        e_write = (mq.size() != 0) && !bus.rf_hold;
        e_rd    = (mq.size() != 0) ? mq[0][AW+DW-1:DW] : '0;
        e_data  = (mq.size() != 0) ? mq[0][DW-1:0]     : '0;
    endtask

    function automatic logic [DW:0] model_fwd(input logic [AW-1:0] a);
        logic [DW:0] res;
        res = '0;
        foreach (mq[i])
            if (a != 0 && mq[i][AW+DW-1:DW] == a) res = {1'b1, mq[i][DW-1:0]};
        return res;
    endfunction

    // Advance one clock; model follows the handshake rules using pre-edge inputs.
    task automatic tick();
        bit acc, drn;
        logic [AW+DW-1:0] ent;
        acc = bus.wb_valid && (mq.size() < DEPTH);
        drn = (mq.size() != 0) && !bus.rf_hold;
        ent = {bus.wb_rd, bus.wb_data};
        @(posedge clk);
        if (!rst) begin
            if (drn) void'(mq.pop_front());
            if (acc && ent[AW+DW-1:DW] != 0) mq.push_back(ent);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 0);
`ifdef WBQ_BYPASS_EN
        bus.rs = 0; bus.rt = 0;
`endif
        #1;
        checks++;
        if ({bus.write, bus.rd, bus.input_data, bus.wb_ready} !== {1'b0, 5'd0, 32'd0, 1'b1}) begin
            failures++;
            $display("FAIL reset_outputs: got w=%b rd=%0d d=%0h rdy=%b want 0 0 0 1",
                     bus.write, bus.rd, bus.input_data, bus.wb_ready);
        end
`ifdef WBQ_BYPASS_EN
        checks++;
        if ({bus.rs_hit, bus.rt_hit, bus.rs_fwd, bus.rt_fwd} !== '0) begin
            failures++;
            $display("FAIL reset_fwd: got %b %b %0h %0h want all 0",
                     bus.rs_hit, bus.rt_hit, bus.rs_fwd, bus.rt_fwd);
        end
`endif
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (bus.write !== 1'b0 || bus.wb_ready !== 1'b1) begin
            failures++;
            $display("FAIL post_reset: got w=%b rdy=%b want 0 1", bus.write, bus.wb_ready);
        end
    endtask

    task automatic test_basic();
        drive(1, 2, 3, 0);
        #1;
        checks++;
        if (bus.wb_ready !== 1'b1 || bus.write !== 1'b0) begin
            failures++;
            $display("FAIL basic_accept: got rdy=%b w=%b want 1 0", bus.wb_ready, bus.write);
        end
        tick();
        drive(0, 0, 0, 0);
        #1;
        checks++;
        if ({bus.write, bus.rd, bus.input_data} !== {1'b1, 5'd2, 32'd3}) begin
            failures++;
            $display("FAIL basic_write: got w=%b rd=%0d d=%0d want 1 2 3", bus.write, bus.rd, bus.input_data);
        end
        tick();
        #1;
        checks++;
        if ({bus.write, bus.rd, bus.input_data} !== {1'b0, 5'd0, 32'd0}) begin
            failures++;
            $display("FAIL basic_idle: got w=%b rd=%0d d=%0d want 0 0 0", bus.write, bus.rd, bus.input_data);
        end
    endtask

    task automatic test_r0();
        drive(1, 0, 7, 0);
        #1;
        checks++;
        if (bus.wb_ready !== 1'b1) begin
            failures++;
            $display("FAIL r0_ready: got %b want 1", bus.wb_ready);
        end
        tick();
        drive(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (bus.write !== 1'b0 || bus.rd !== '0) begin
                failures++;
                $display("FAIL r0_no_write: cycle %0d got w=%b rd=%0d want 0 0", i, bus.write, bus.rd);
            end
            tick();
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, AW'(4 + i), DW'(100 + i), 1);
            #1;
            checks++;
            if (bus.wb_ready !== 1'b1 || bus.write !== 1'b0) begin
                failures++;
                $display("FAIL fill_accept: entry %0d got rdy=%b w=%b want 1 0", i, bus.wb_ready, bus.write);
            end
            tick();
        end
        drive(0, 0, 0, 1);
        #1;
        checks++;
        if (bus.wb_ready !== 1'b0) begin
            failures++;
            $display("FAIL fill_full: got rdy=%b want 0", bus.wb_ready);
        end
        drive(0, 0, 0, 0);
        #1;
        checks++;
        if (bus.wb_ready !== 1'b0 || bus.write !== 1'b1) begin
            failures++;
            $display("FAIL fill_drain_ready: got rdy=%b w=%b want 0 1", bus.wb_ready, bus.write);
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (i > 0) #1;
            checks++;
            if ({bus.write, bus.rd, bus.input_data} !== {1'b1, AW'(4 + i), DW'(100 + i)}) begin
                failures++;
                $display("FAIL fill_order: slot %0d got w=%b rd=%0d d=%0d want 1 %0d %0d",
                         i, bus.write, bus.rd, bus.input_data, 4 + i, 100 + i);
            end
            if (i > 0) begin
                checks++;
                if (bus.wb_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL fill_ready_back: slot %0d got %b want 1", i, bus.wb_ready);
                end
            end
            tick();
        end
        #1;
        checks++;
        if (bus.write !== 1'b0) begin
            failures++;
            $display("FAIL fill_empty: got w=%b want 0", bus.write);
        end
    endtask

    task automatic test_wrap();
        for (int i = 1; i <= 10; i++) begin
            drive(1, AW'(i), DW'(i * 3), 0);
            #1;
            if (i > 1) begin
                checks++;
                if ({bus.write, bus.rd, bus.input_data} !== {1'b1, AW'(i - 1), DW'((i - 1) * 3)}) begin
                    failures++;
                    $display("FAIL wrap_seq: step %0d got w=%b rd=%0d d=%0d want 1 %0d %0d",
                             i, bus.write, bus.rd, bus.input_data, i - 1, (i - 1) * 3);
                end
            end
            tick();
        end
        drive(0, 0, 0, 0);
        #1;
        checks++;
        if ({bus.write, bus.rd, bus.input_data} !== {1'b1, 5'd10, 32'd30}) begin
            failures++;
            $display("FAIL wrap_last: got w=%b rd=%0d d=%0d want 1 10 30", bus.write, bus.rd, bus.input_data);
        end
        tick();
        #1;
        checks++;
        if (bus.write !== 1'b0) begin
            failures++;
            $display("FAIL wrap_empty: got w=%b want 0", bus.write);
        end
    endtask

`ifdef WBQ_BYPASS_EN
    task automatic test_fwd();
        drive(1, 2, 6, 1);
        tick();
        drive(1, 2, 9, 1);
        tick();
        drive(0, 0, 0, 1);
        bus.rs = 2; bus.rt = 0;
        #1;
        checks++;
        if ({bus.rs_hit, bus.rs_fwd, bus.rt_hit, bus.rt_fwd} !== {1'b1, 32'd9, 1'b0, 32'd0}) begin
            failures++;
            $display("FAIL fwd_youngest: got rs=%b/%0d rt=%b/%0d want 1/9 0/0",
                     bus.rs_hit, bus.rs_fwd, bus.rt_hit, bus.rt_fwd);
        end
        bus.rs = 3;
        drive(0, 0, 0, 0);
        bus.rt = 2;
        #1;
        checks++;
        if ({bus.rs_hit, bus.rs_fwd, bus.rt_hit, bus.rt_fwd} !== {1'b0, 32'd0, 1'b1, 32'd9}) begin
            failures++;
            $display("FAIL fwd_miss_drain: got rs=%b/%0d rt=%b/%0d want 0/0 1/9",
                     bus.rs_hit, bus.rs_fwd, bus.rt_hit, bus.rt_fwd);
        end
        tick();
        tick();
        bus.rs = 0; bus.rt = 0;
    endtask
`endif

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1, AW'(5 + i), DW'(50 + 10 * i), 1);
            tick();
        end
        drive(0, 0, 0, 0);
`ifdef WBQ_BYPASS_EN
        bus.rs = 5; bus.rt = 7;
`endif
        #1;
        checks++;
        if ({bus.write, bus.rd, bus.input_data} !== {1'b1, 5'd5, 32'd50}) begin
            failures++;
            $display("FAIL arst_pre: got w=%b rd=%0d d=%0d want 1 5 50", bus.write, bus.rd, bus.input_data);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({bus.write, bus.rd, bus.input_data, bus.wb_ready} !== {1'b0, 5'd0, 32'd0, 1'b1}) begin
            failures++;
            $display("FAIL arst_clear: got w=%b rd=%0d d=%0d rdy=%b want 0 0 0 1",
                     bus.write, bus.rd, bus.input_data, bus.wb_ready);
        end
`ifdef WBQ_BYPASS_EN
        checks++;
        if ({bus.rs_hit, bus.rt_hit, bus.rs_fwd, bus.rt_fwd} !== '0) begin
            failures++;
            $display("FAIL arst_fwd: got %b %b %0h %0h want all 0", bus.rs_hit, bus.rt_hit, bus.rs_fwd, bus.rt_fwd);
        end
`endif
        mq.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (bus.write !== 1'b0) begin
                failures++;
                $display("FAIL arst_no_write: cycle %0d got w=%b want 0", i, bus.write);
            end
            tick();
        end
    endtask

    task automatic test_random();
        bit pend = 0;
        bit acc;
        logic [AW-1:0] r = '0;
        logic [DW-1:0] d = '0;
        logic [DW:0]   ef;
        for (int n = 0; n < 400; n++) begin
            // Producer holds a request stable until it is accepted.
            if (!pend && $urandom_range(2) != 0) begin
                pend = 1;
                r    = AW'($urandom_range(7));
                d    = $urandom;
            end
            drive(pend, r, d, $urandom_range(3) == 0);
`ifdef WBQ_BYPASS_EN
            bus.rs = AW'($urandom_range(7));
            bus.rt = AW'($urandom_range(7));
`endif
            #1;
            predict();
            checks++;
            if ({bus.write, bus.rd, bus.input_data, bus.wb_ready} !== {e_write, e_rd, e_data, e_ready}) begin
                failures++;
                $display("FAIL rand_port: cycle %0d got w=%b rd=%0d d=%0h rdy=%b want %b %0d %0h %b",
                         n, bus.write, bus.rd, bus.input_data, bus.wb_ready, e_write, e_rd, e_data, e_ready);
            end
`ifdef WBQ_BYPASS_EN
            ef = model_fwd(bus.rs);
            checks++;
            if ({bus.rs_hit, bus.rs_fwd} !== ef) begin
                failures++;
                $display("FAIL rand_rs_fwd: cycle %0d got %b/%0h want %b/%0h", n, bus.rs_hit, bus.rs_fwd, ef[DW], ef[DW-1:0]);
            end
            ef = model_fwd(bus.rt);
            checks++;
            if ({bus.rt_hit, bus.rt_fwd} !== ef) begin
                failures++;
                $display("FAIL rand_rt_fwd: cycle %0d got %b/%0h want %b/%0h", n, bus.rt_hit, bus.rt_fwd, ef[DW], ef[DW-1:0]);
            end
`else
            ef = model_fwd(r);
`endif
            acc = pend && (mq.size() < DEPTH);
            tick();
            if (acc) pend = 0;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_r0();
        test_fill();
        test_wrap();
`ifdef WBQ_BYPASS_EN
        test_fwd();
`endif
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
